rank_classifier: RTL
====================

# rank_classifier

Collects the per-kernel mismatch scores produced by the corner-glyph XOR matchers and selects the best-matching card rank. It sits directly downstream of the XOR matcher bank and upstream of the card-decode/display logic. It latches one score per kernel as each arrives, scans for the minimum once all are in, applies an acceptance threshold, and holds the result under a valid/ready handshake.

## Interface
- NUM_KERNELS, 13, number of rank kernels/matchers feeding the block (index 0 = ace … 12 = king)
- SCORE_W, 11, score width; equals $clog2(corner_width*rank_height) = $clog2(1120)
- THRESH, 280, maximum score accepted as a valid match (inclusive)
- TIMEOUT_CYCLES, 4096, collection timeout; used only with RANK_TIMEOUT_EN
- clk  in  1  system clock, all logic on posedge
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse; clears collection and starts a new frame
- score_in  in  NUM_KERNELS*SCORE_W  packed scores; kernel i at bits [i*SCORE_W +: SCORE_W]
- score_valid  in  NUM_KERNELS  per-kernel one-cycle strobe; score_in slice valid that cycle
- rank_ready  in  1  consumer accepts the result
- rank_valid  out  1  result available; held until accepted
- rank_out  out  $clog2(NUM_KERNELS)  index of minimum-score kernel
- best_score  out  SCORE_W  minimum score found
- rank_found  out  1  best_score <= THRESH
- timed_out  out  1  result produced by timeout (tied 0 without RANK_TIMEOUT_EN)

## Operation
- States: IDLE, COLLECT, SCAN, HOLD. Reset → IDLE; all outputs 0; score registers and seen mask cleared.
- IDLE: frame_start → COLLECT. score_valid ignored.
- COLLECT: on score_valid[i] with seen[i]=0, latch the slice into reg[i] and set seen[i]. A repeat strobe for a kernel already seen is ignored (first wins). Several strobes in the same cycle are all latched. When seen is all-ones → SCAN.
- SCAN: one kernel per cycle, index 0 to NUM_KERNELS-1. Strict less-than compare against the running minimum, seeded with all-ones. Ties keep the lower index. Unseen kernels (timeout only) count as all-ones. After the last index → HOLD.
- HOLD: rank_valid=1. rank_out, best_score, rank_found and timed_out are stable. When rank_valid && rank_ready → IDLE, rank_valid drops the next cycle.
- rank_found = (best_score <= THRESH), registered with the result. rank_out is reported even when rank_found=0.
- frame_start in any state: clear the seen mask, drop rank_valid, → COLLECT. This takes precedence over every other transition in that cycle, including acceptance in HOLD. A result not yet accepted is discarded.
- score_valid during SCAN or HOLD is ignored.

## Timing
- Final strobe sampled at edge t. SCAN entered at t+1. Compares run on edges t+2 … t+NUM_KERNELS+1. rank_valid goes high after edge t+NUM_KERNELS+2. With the default parameters this is 15 cycles.
- Handshake is registered. The earliest re-arm is the cycle after acceptance.
- Reset asserted mid-operation clears everything immediately, with no handshake completion.

## Configuration
- RANK_TIMEOUT_EN defined: a counter runs while in COLLECT. It resets on entry and on frame_start. If it reaches TIMEOUT_CYCLES before all kernels are seen, the block enters SCAN with the seen kernels only and sets timed_out=1 for that result. If no kernel was seen: best_score = all-ones, rank_out = 0, rank_found = 0.
- RANK_TIMEOUT_EN undefined: no counter. COLLECT waits indefinitely. timed_out is constant 0.

## Test plan
- All 13 strobes in one cycle, kernel 4 = 37, others ≥ 500 → after 15 cycles rank_valid=1, rank_out=4, best_score=37, rank_found=1.
- Kernels 2 and 9 both score 100, strobes staggered in random order → rank_out=2, best_score=100.
- Minimum score 281 → rank_found=0, rank_out = its index; with THRESH=281 the same input gives rank_found=1.
- rank_ready held low for 50 cycles → outputs stable, rank_valid stays 1; on the ready pulse, rank_valid=0 next cycle and state returns to IDLE; a duplicate strobe for kernel 4 during COLLECT does not change reg[4].
- frame_start mid-COLLECT after 6 kernels, then all 13 arrive → the result uses only post-restart values; rst pulled low mid-SCAN → all outputs 0 immediately, no rank_valid.
- RANK_TIMEOUT_EN, only 12 kernels strobed → rank_valid TIMEOUT_CYCLES+14 cycles after frame_start, timed_out=1, missing kernel never selected.

Source files
------------

// File: rtl/rank_classifier.sv
// rank_classifier: collects one mismatch score per rank kernel, scans for the
// minimum, applies the acceptance threshold and holds the result under a
// valid/ready handshake.
// Optional feature macro: RANK_TIMEOUT_EN (collection timeout, timed_out flag).
// rst is asynchronous and active-low.
module rank_classifier #(
    parameter int NUM_KERNELS    = 13,
    parameter int SCORE_W        = 11,
    parameter int THRESH         = 280,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           frame_start,
    input  logic [NUM_KERNELS*SCORE_W-1:0] score_in,
    input  logic [NUM_KERNELS-1:0]         score_valid,
    input  logic                           rank_ready,
    output logic                           rank_valid,
    output logic [$clog2(NUM_KERNELS)-1:0] rank_out,
    output logic [SCORE_W-1:0]             best_score,
    output logic                           rank_found,
    output logic                           timed_out
);
    localparam int IDX_W  = $clog2(NUM_KERNELS);
    localparam int SCAN_W = $clog2(NUM_KERNELS + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, SCAN, HOLD} state_t;

    state_t               state_reg, state_next;
    logic [NUM_KERNELS-1:0] seen_reg;
    logic [SCORE_W-1:0]   score_reg [NUM_KERNELS];
    logic [SCORE_W-1:0]   score_slice [NUM_KERNELS];
    logic [NUM_KERNELS-1:0] take;
    logic [SCAN_W-1:0]    scan_idx_reg;
    logic [SCORE_W-1:0]   min_reg;
    logic [IDX_W-1:0]     min_idx_reg;
    logic [SCORE_W-1:0]   cur_score;
    logic                 scan_last;
    logic                 timeout_hit;
    logic                 rank_valid_reg;
    logic [IDX_W-1:0]     rank_out_reg;
    logic [SCORE_W-1:0]   best_reg;
    logic                 found_reg;

    // Per-kernel slice extraction and first-wins latch enable
    generate
        for (genvar gi = 0; gi < NUM_KERNELS; gi++) begin : g_kernel
            assign score_slice[gi] = score_in[gi*SCORE_W +: SCORE_W];
            assign take[gi] = (state_reg == COLLECT) && !frame_start &&
                              score_valid[gi] && !seen_reg[gi];
        end
    endgenerate

    assign scan_last = (scan_idx_reg == SCAN_W'(NUM_KERNELS));

`ifdef RANK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_reg;
    logic             timed_out_reg;

    // Collection timer: counts only while collecting, restarts on every frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_reg <= '0;
        else if (frame_start || state_reg != COLLECT)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign timeout_hit = (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

    // A result is a timeout result exactly when some kernel never reported
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            timed_out_reg <= 1'b0;
        else if (!frame_start && state_reg == SCAN && scan_last)
            timed_out_reg <= ~&seen_reg;
    end

    assign timed_out = timed_out_reg;
`else
    assign timeout_hit = 1'b0;
    assign timed_out   = 1'b0;
`endif

    // Score and seen-mask registers; frame_start wipes the mask
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seen_reg <= '0;
            for (int k = 0; k < NUM_KERNELS; k++) score_reg[k] <= '0;
        end else if (frame_start) begin
            seen_reg <= '0;
        end else begin
            for (int k = 0; k < NUM_KERNELS; k++) begin
                if (take[k]) begin
                    score_reg[k] <= score_slice[k];
                    seen_reg[k]  <= 1'b1;
                end
            end
        end
    end

    // Score of the kernel under scan; unseen kernels read as worst possible
    always_comb begin
        cur_score = '1;
        for (int k = 0; k < NUM_KERNELS; k++) begin
            if (scan_idx_reg == SCAN_W'(k) && seen_reg[k]) cur_score = score_reg[k];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Next-state logic; frame_start overrides every other transition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    state_next = IDLE;
            COLLECT: if (&seen_reg || timeout_hit) state_next = SCAN;
            SCAN:    if (scan_last) state_next = HOLD;
            HOLD:    if (rank_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (frame_start) state_next = COLLECT;
    end

    // Minimum scan and result/handshake registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_idx_reg   <= '0;
            min_reg        <= '0;
            min_idx_reg    <= '0;
            rank_valid_reg <= 1'b0;
            rank_out_reg   <= '0;
            best_reg       <= '0;
            found_reg      <= 1'b0;
        end else begin
            if (state_reg == COLLECT) begin
                scan_idx_reg <= '0;
                min_reg      <= '1;
                min_idx_reg  <= '0;
            end
            if (state_reg == SCAN && !scan_last) begin
                if (cur_score < min_reg) begin
                    min_reg     <= cur_score;
                    min_idx_reg <= IDX_W'(scan_idx_reg);
                end
                scan_idx_reg <= scan_idx_reg + 1'b1;
            end
            if (frame_start) begin
                rank_valid_reg <= 1'b0;
            end else if (state_reg == SCAN && scan_last) begin
                rank_out_reg   <= min_idx_reg;
                best_reg       <= min_reg;
                found_reg      <= (min_reg <= SCORE_W'(THRESH));
                rank_valid_reg <= 1'b1;
            end else if (state_reg == HOLD && rank_ready) begin
                rank_valid_reg <= 1'b0;
            end
        end
    end

    assign rank_valid = rank_valid_reg;
    assign rank_out   = rank_out_reg;
    assign best_score = best_reg;
    assign rank_found = found_reg;

endmodule
